// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM -> WB stage bus.
//   Carries the MEM-stage instruction fields, the stall/flush controls and the
//   write-back results (register-file write port, EX forwarding bus, misalign trap).
//   master: MEM stage / pipeline control side (drives in_*, wb_stall, wb_flush).
//   slave : wb_stage_pipe (drives rf_*, fwd_*, misalign).
// Parameters: DATA_W datapath width, REG_AW register address width.
interface wb_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              in_valid;
    logic              in_regwrite;
    logic [1:0]        in_wb_sel;
    logic [1:0]        in_mem_size;
    logic              in_mem_uns;
    logic [1:0]        in_addr_lo;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_mem;
    logic [DATA_W-1:0] in_link;
    logic [REG_AW-1:0] in_rd;
    logic              wb_stall;
    logic              wb_flush;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic              misalign;

    modport master (
        output in_valid, in_regwrite, in_wb_sel, in_mem_size, in_mem_uns, in_addr_lo,
        output in_alu, in_mem, in_link, in_rd, wb_stall, wb_flush,
        input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, misalign
    );

    modport slave (
        input  in_valid, in_regwrite, in_wb_sel, in_mem_size, in_mem_uns, in_addr_lo,
        input  in_alu, in_mem, in_link, in_rd, wb_stall, wb_flush,
        output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, misalign
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered MEM/WB stage plus write-back unit.
//   Captures MEM-stage results, extends loads by size/byte lane (little-endian),
//   selects ALU / memory / link data and drives the register-file write port and
//   the EX forwarding bus. Supports stall, flush, a misaligned-load trap and a
//   single write pulse per instruction across stalls.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        wb_stage_if.slave (in_*, wb_stall, wb_flush in; rf_*, fwd_*, misalign out)
//   retire_cnt retired-instruction counter (only with WB_RETIRE_CNT_EN)
// Configuration macro: WB_RETIRE_CNT_EN adds the retire_cnt port and counter.
// Load extension assumes DATA_W == 32.
module wb_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_stage_if.slave        bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);
    localparam logic [1:0] SelAlu  = 2'b00;
    localparam logic [1:0] SelMem  = 2'b01;
    localparam logic [1:0] SelLink = 2'b10;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;

    logic              valid_q;
    logic              fired_q;
    logic              regwrite_q;
    logic [1:0]        sel_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        addr_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] link_q;
    logic [REG_AW-1:0] rd_q;

    // Priority: flush > stall > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            fired_q    <= 1'b0;
            regwrite_q <= 1'b0;
            sel_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            alu_q      <= '0;
            mem_q      <= '0;
            link_q     <= '0;
            rd_q       <= '0;
        end else if (bus.wb_flush) begin
            valid_q <= 1'b0;
            fired_q <= 1'b0;
        end else if (bus.wb_stall) begin
            // The held instruction has already had its one cycle on the write port.
            if (valid_q) begin
                fired_q <= 1'b1;
            end
        end else begin
            valid_q    <= bus.in_valid;
            fired_q    <= 1'b0;
            regwrite_q <= bus.in_regwrite;
            sel_q      <= bus.in_wb_sel;
            size_q     <= bus.in_mem_size;
            uns_q      <= bus.in_mem_uns;
            addr_q     <= bus.in_addr_lo;
            alu_q      <= bus.in_alu;
            mem_q      <= bus.in_mem;
            link_q     <= bus.in_link;
            rd_q       <= bus.in_rd;
        end
    end

    logic is_mem;
    logic misalign_cond;
    logic writes_reg;

    // Size 11 is treated as a word access.
    assign is_mem        = (sel_q == SelMem);
    assign misalign_cond = is_mem &
                           (((size_q == SizeHalf) & addr_q[0]) |
                            (size_q[1] & (addr_q != 2'b00)));
    assign writes_reg    = valid_q & regwrite_q & (rd_q != '0);

    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] load_ext;

    always_comb begin
        byte_lane = 8'h00;
        half_lane = addr_q[1] ? mem_q[31:16] : mem_q[15:0];
        load_ext  = mem_q;
        unique case (addr_q)
            2'b00: byte_lane = mem_q[7:0];
            2'b01: byte_lane = mem_q[15:8];
            2'b10: byte_lane = mem_q[23:16];
            2'b11: byte_lane = mem_q[31:24];
            default: byte_lane = mem_q[7:0];
        endcase
        if (size_q == SizeByte) begin
            load_ext = {{(DATA_W-8){byte_lane[7] & ~uns_q}}, byte_lane};
        end else if (size_q == SizeHalf) begin
            load_ext = {{(DATA_W-16){half_lane[15] & ~uns_q}}, half_lane};
        end
    end

    logic [DATA_W-1:0] wdata;

    always_comb begin
        wdata = alu_q;
        case (sel_q)
            SelAlu:  wdata = alu_q;
            SelMem:  wdata = load_ext;
            SelLink: wdata = link_q;
            default: wdata = alu_q;  // reserved encoding behaves as ALU
        endcase
    end

    assign bus.rf_we     = writes_reg & ~fired_q & ~misalign_cond;
    assign bus.rf_waddr  = rd_q;
    assign bus.rf_wdata  = wdata;
    assign bus.fwd_valid = writes_reg & ~misalign_cond;
    assign bus.fwd_rd    = rd_q;
    assign bus.fwd_data  = wdata;
    assign bus.misalign  = valid_q & misalign_cond & ~fired_q;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q;

    // Counts every retiring instruction, including non-writing ones; trapped loads excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (valid_q & ~fired_q & ~bus.misalign) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif
endmodule
